hub75_frame_buffer: RTL and testbench

- Double-buffered pixel store for the 64x32 HUB75 panel. Sits directly upstream of the row shifter.
- The host/pattern side writes 3-bit RGB pixels into the back bank.
- The scan side reads the front bank one column at a time, returning the upper-half pixel (rgb1) and the lower-half pixel (rgb2) together.
- Bank swap happens only at a frame boundary, so the display never tears.

---
 rtl/hub75_frame_buffer.sv | 111 +++++++++++
 tb/tb_hub75_frame_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_frame_buffer.sv
// hub75_frame_buffer: double-buffered 64x32 RGB pixel store for a HUB75 panel
// Ports:
//   clk, rst_n                     pixel clock, asynchronous active-low reset
//   wr_en, wr_x, wr_y, wr_rgb      pixel write into the back bank (dropped while busy)
//   clear_req, clear_rgb, busy     fill the back bank with one colour, busy during the sweep
//   swap_req, frame_end, swap_done request a bank exchange, taken at the next idle frame end
//   front_sel                      bank currently displayed
//   rd_en, rd_col, rd_row          scan read of the front bank
//   rd_rgb1, rd_rgb2, rd_valid     upper/lower half pixels, one cycle after rd_en
module hub75_frame_buffer #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 32,
    parameter int CW     = 6,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_x,
    input  logic [RW-1:0] wr_y,
    input  logic [2:0]    wr_rgb,
    input  logic          clear_req,
    input  logic [2:0]    clear_rgb,
    output logic          busy,
    input  logic          swap_req,
    input  logic          frame_end,
    output logic          swap_done,
    output logic          front_sel,
    input  logic          rd_en,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-2:0] rd_row,
    output logic [2:0]    rd_rgb1,
    output logic [2:0]    rd_rgb2,
    output logic          rd_valid
);
    localparam int DEPTH = WIDTH * HEIGHT / 2;
    localparam int AW    = CW + RW - 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_cnt;
    logic [2:0]    r_clr_rgb;
    logic          r_pending, r_front, r_swap_done, r_rd_valid;
    logic [2:0]    r_rgb1, r_rgb2;
    logic [2:0]    r_top [2][DEPTH];
    logic [2:0]    r_bot [2][DEPTH];

    logic          w_busy, w_back, w_swap, w_top_we, w_bot_we;
    logic [AW-1:0] w_waddr, w_raddr;
    logic [2:0]    w_wdata;

    assign w_busy = (r_state == CLEAR);
    assign w_back = ~r_front;
    // A swap is blocked during a clear so the sweep can never land on the displayed bank
    assign w_swap = frame_end & r_pending & ~w_busy;

    // The clear sweep owns the write port; host writes during it are discarded
    assign w_top_we = w_busy | (wr_en & ~wr_y[RW-1]);
    assign w_bot_we = w_busy | (wr_en & wr_y[RW-1]);
    assign w_waddr  = w_busy ? r_cnt : {wr_y[RW-2:0], wr_x};
    assign w_wdata  = w_busy ? r_clr_rgb : wr_rgb;
    assign w_raddr  = {rd_row, rd_col};

    always_comb begin
        w_next = (r_state == IDLE) ? (clear_req ? CLEAR : IDLE)
                                   : ((r_cnt == AW'(DEPTH - 1)) ? IDLE : CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_clr_rgb   <= '0;
            r_pending   <= 1'b0;
            r_front     <= 1'b0;
            r_swap_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rgb1      <= '0;
            r_rgb2      <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_busy ? r_cnt + 1'b1 : '0;
            if (!w_busy && clear_req)
                r_clr_rgb <= clear_rgb;
            r_pending   <= ~w_swap & (r_pending | swap_req);
            r_front     <= r_front ^ w_swap;
            r_swap_done <= w_swap;
            r_rd_valid  <= rd_en;
            if (rd_en) begin
                r_rgb1 <= r_top[r_front][w_raddr];
                r_rgb2 <= r_bot[r_front][w_raddr];
            end
        end
    end

    // Pixel storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_top_we)
            r_top[w_back][w_waddr] <= w_wdata;
        if (w_bot_we)
            r_bot[w_back][w_waddr] <= w_wdata;
    end

    assign busy      = w_busy;
    assign swap_done = r_swap_done;
    assign front_sel = r_front;
    assign rd_rgb1   = r_rgb1;
    assign rd_rgb2   = r_rgb2;
    assign rd_valid  = r_rd_valid;
endmodule

// File: tb/tb_hub75_frame_buffer.sv
// tb_hub75_frame_buffer: scoreboard bench for hub75_frame_buffer
module tb_hub75_frame_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_x = '0;
    logic [4:0] wr_y = '0;
    logic [2:0] wr_rgb = '0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_rgb = '0;
    logic       busy;
    logic       swap_req = 1'b0;
    logic       frame_end = 1'b0;
    logic       swap_done;
    logic       front_sel;
    logic       rd_en = 1'b0;
    logic [5:0] rd_col = '0;
    logic [3:0] rd_row = '0;
    logic [2:0] rd_rgb1, rd_rgb2;
    logic       rd_valid;

    int checks = 0;
    int errors = 0;
    int sd_cnt = 0;
    logic [5:0] exp_q[$];

    hub75_frame_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .clear_req(clear_req), .clear_rgb(clear_rgb), .busy(busy),
        .swap_req(swap_req), .frame_end(frame_end), .swap_done(swap_done),
        .front_sel(front_sel),
        .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
        .rd_rgb1(rd_rgb1), .rd_rgb2(rd_rgb2), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // Monitor: every valid read result is matched against the oldest expectation
    always @(negedge clk) begin
        if (swap_done)
            sd_cnt++;
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%b_%b required=no data", rd_rgb1, rd_rgb2);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({rd_rgb1, rd_rgb2} !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%b_%b required=%b_%b", rd_rgb1, rd_rgb2, e[5:3], e[2:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wr(input int x, input int y, input logic [2:0] c);
        wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_rgb = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int row, input int col, input logic [2:0] e1, input logic [2:0] e2);
        rd_en = 1'b1; rd_row = 4'(row); rd_col = 6'(col);
        exp_q.push_back({e1, e2});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic do_swap(input logic exp_front);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_pulse();
        chk("swap_done_pulse", int'(swap_done), 1);
        chk("front_after_swap", int'(front_sel), int'(exp_front));
        tick();
        chk("swap_done_single", int'(swap_done), 0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            n++;
            tick();
        end
        chk(name, int'(busy), 0);
    endtask

    initial begin
        int n, sd0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_front", int'(front_sel), 0);
        chk("rst_swap_done", int'(swap_done), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rgb", int'({rd_rgb1, rd_rgb2}), 0);
        rst_n = 1'b1;
        tick();

        // Clear back bank (1) to 010; busy must last exactly 1024 cycles
        clear_req = 1'b1; clear_rgb = 3'b010;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick();
        end
        chk("clear_busy_cycles", n, 1024);
        do_swap(1'b1);
        rd(0, 0, 3'b010, 3'b010);
        rd(15, 63, 3'b010, 3'b010);
        rd(7, 33, 3'b010, 3'b010);
        tick();
        chk("rd_valid_drops", int'(rd_valid), 0);

        // Writes land in bank 0; front bank still shows the clear colour until the swap
        wr(5, 3, 3'b100);
        wr(5, 19, 3'b001);
        rd(3, 5, 3'b010, 3'b010);
        do_swap(1'b0);
        rd(3, 5, 3'b100, 3'b001);

        // Pending swap waits for frame_end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        sd0 = sd_cnt;
        repeat (100) tick();
        chk("no_swap_without_frame_end", sd_cnt - sd0, 0);
        chk("front_held", int'(front_sel), 0);
        frame_pulse();
        chk("late_swap_done", int'(swap_done), 1);
        repeat (3) tick();
        chk("late_swap_single", sd_cnt - sd0, 1);
        chk("late_swap_front", int'(front_sel), 1);

        // Clear bank 0 to 101 with a swap pending; frame_end during busy is ignored
        clear_req = 1'b1; clear_rgb = 3'b101; swap_req = 1'b1;
        tick();
        clear_req = 1'b0; swap_req = 1'b0;
        wr(0, 0, 3'b111);
        repeat (8) tick();
        sd0 = sd_cnt;
        frame_pulse();
        tick();
        chk("busy_blocks_swap", sd_cnt - sd0, 0);
        chk("busy_front_held", int'(front_sel), 1);
        wait_idle("clear2_finishes");
        frame_pulse();
        chk("swap_after_clear", int'(swap_done), 1);
        chk("front_after_clear", int'(front_sel), 0);
        rd(0, 0, 3'b101, 3'b101);
        rd(15, 63, 3'b101, 3'b101);

        // Reset in the middle of a clear sweep
        do_swap(1'b1);
        clear_req = 1'b1; clear_rgb = 3'b110;
        tick();
        clear_req = 1'b0;
        repeat (498) tick();
        rd(0, 0, 3'b010, 3'b010);
        @(negedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_valid", int'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_front", int'(front_sel), 0);
        chk("arst_swap_done", int'(swap_done), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_rgb", int'({rd_rgb1, rd_rgb2}), 0);
        #6;
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", int'(busy), 0);

        // After reset, back bank is 1 again
        wr(7, 2, 3'b011);
        wr(7, 18, 3'b110);
        do_swap(1'b1);
        rd(2, 7, 3'b011, 3'b110);
        rd(0, 0, 3'b010, 3'b010);
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
